ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 103 ++++++++++
 tb/tb_ifetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: two-state FETCH/HOLD sequencer with PC update,
// jump/branch target selection, retire counter and sticky ack-timeout flag.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic        fetch_err
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [0:0]        state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic [31:0]       pc_nx, instr_nx, retired_nx;
    logic              err_nx;
    logic              take_jump, take_br;
    logic [31:0]       br_off, jump_tgt, next_pc;

    assign imem_req    = (state == S_FETCH);
    assign instr_valid = (state == S_HOLD);
    assign imem_addr   = pc;
    assign pc_plus4    = 32'(pc + 32'd4);
    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];

    // Control-flow target selection for the held instruction
    assign take_jump = jump | (branch == 2'b11);
    assign take_br   = ((branch == 2'b10) & zero) | ((branch == 2'b01) & ~zero);
    assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_tgt  = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign next_pc   = take_jump ? jump_tgt :
                       take_br   ? 32'(pc_plus4 + br_off) : pc_plus4;

    always_comb begin
        state_nx   = state;
        wait_nx    = wait_cnt;
        pc_nx      = pc;
        instr_nx   = instr;
        retired_nx = retired;
        err_nx     = fetch_err;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_nx = imem_rdata;
                    wait_nx  = '0;
                    state_nx = S_HOLD;
                end else begin
                    if (wait_cnt != {WAIT_W{1'b1}}) begin
                        wait_nx = WAIT_W'(wait_cnt + WAIT_W'(1));
                    end
                    if (32'(wait_nx) >= 32'(TIMEOUT)) begin
                        err_nx = 1'b1;
                    end
                end
            end
            default: begin
                if (!stall) begin
                    pc_nx      = next_pc;
                    retired_nx = 32'(retired + 32'd1);
                    state_nx   = S_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            pc        <= RESET_PC;
            instr     <= '0;
            retired   <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            pc        <= pc_nx;
            instr     <= instr_nx;
            retired   <= retired_nx;
            fetch_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the fetch sequence.
module tb_ifetch_unit;

    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst, stall, jump, zero, imem_ack;
    logic [1:0]  branch;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired;
    logic [5:0]  opcode, funct;

    int checks = 0;
    int errors = 0;

    // model state
    bit          m_hold;
    logic [31:0] m_pc, m_instr, m_ret;
    bit          m_err;
    int          m_wait;

    ifetch_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump), .branch(branch),
        .zero(zero), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
        .opcode(opcode), .funct(funct), .instr_valid(instr_valid), .pc(pc),
        .pc_plus4(pc_plus4), .retired(retired), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of reference behaviour using the inputs currently applied
    task automatic model_step();
        logic [31:0] p4;
        int off;
        if (rst) begin
            m_hold = 0; m_pc = RPC; m_instr = 0; m_ret = 0; m_err = 0; m_wait = 0;
        end else if (!m_hold) begin
            if (imem_ack) begin
                m_instr = imem_rdata; m_wait = 0; m_hold = 1;
            end else begin
                if (m_wait < 255) m_wait++;
                if (m_wait >= TMO) m_err = 1;
            end
        end else if (!stall) begin
            p4 = m_pc + 32'd4;
            if (jump || branch == 2'b11)
                m_pc = (p4 & 32'hF000_0000) + (m_instr & 32'h03FF_FFFF) * 32'd4;
            else if ((branch == 2'b10 && zero) || (branch == 2'b01 && !zero)) begin
                off = int'($signed(m_instr[15:0]));
                m_pc = p4 + 32'(off * 4);
            end else
                m_pc = p4;
            m_ret = m_ret + 32'd1;
            m_hold = 0;
        end
    endtask

    task automatic check_all();
        chk("imem_req", 32'(imem_req), 32'(!m_hold));
        chk("instr_valid", 32'(instr_valid), 32'(m_hold));
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr", instr, m_instr);
        chk("opcode", 32'(opcode), m_instr >> 26);
        chk("funct", 32'(funct), m_instr & 32'h3F);
        chk("retired", retired, m_ret);
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic randomize_ctrl();
        jump   = 1'($urandom_range(0, 1));
        branch = 2'($urandom_range(0, 3));
        zero   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1; stall = 1; imem_ack = 1; imem_rdata = $urandom; randomize_ctrl();
        tick();
        rst = 0; imem_ack = 0;
    endtask

    // FETCH with immediate ack, then one HOLD cycle leaving with the given controls
    task automatic run_instr(input logic [31:0] w, input logic j, input logic [1:0] b, input logic z);
        stall = 1'($urandom_range(0, 1)); randomize_ctrl();
        imem_ack = 1; imem_rdata = w;
        tick();
        stall = 0; jump = j; branch = b; zero = z;
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        tick();
        imem_ack = 0;
    endtask

    initial begin
        rst = 0; stall = 0; jump = 0; branch = 0; zero = 0; imem_ack = 0; imem_rdata = 0;
        m_hold = 0; m_pc = RPC; m_instr = 0; m_ret = 0; m_err = 0; m_wait = 0;
        @(negedge clk);

        // reset state
        do_reset();
        chk("reset_pc", pc, 32'h0000_3000);
        chk("reset_req", 32'(imem_req), 32'd1);

        // sequential fetch
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imem_addr, 32'h3000 + 32'(4 * i));
            run_instr(32'h3C01_0001, 1'b0, 2'b00, 1'b0);
        end
        chk("seq_retired", retired, 32'd3);
        run_instr(32'h3C01_0001, 1'b0, 2'b00, 1'b0);
        chk("at_3010", pc, 32'h3010);

        // branches with imm = -1 from 0x3010
        run_instr(32'h1000_FFFF, 1'b0, 2'b10, 1'b1);
        chk("beq_taken", pc, 32'h3010);
        run_instr(32'h1000_FFFF, 1'b0, 2'b10, 1'b0);
        chk("beq_not_taken", pc, 32'h3014);
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(32'h0, 1'b0, 2'b00, 1'b0);
        run_instr(32'h1400_FFFF, 1'b0, 2'b01, 1'b0);
        chk("bne_taken", pc, 32'h3010);

        // jump beats branch
        do_reset();
        run_instr(32'h0800_0C10, 1'b1, 2'b10, 1'b1);
        chk("jump_prio", pc, 32'h0000_3040);

        // stall in HOLD for 5 cycles
        imem_ack = 1; imem_rdata = 32'hABCD_1234; stall = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            stall = 1; randomize_ctrl(); imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            tick();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, 32'hABCD_1234);
            chk("stall_pc", pc, 32'h3040);
        end
        stall = 0; jump = 0; branch = 0; imem_ack = 0;
        tick();
        chk("stall_release", pc, 32'h3044);

        // ack timeout
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            imem_ack = 0; stall = 1'($urandom_range(0, 1)); randomize_ctrl();
            tick();
            if (i == 15) chk("tmo_before", 32'(fetch_err), 32'd0);
            if (i == 16) chk("tmo_at", 32'(fetch_err), 32'd1);
        end
        run_instr(32'h1234_5678, 1'b0, 2'b00, 1'b0);
        chk("tmo_sticky", 32'(fetch_err), 32'd1);
        do_reset();
        chk("tmo_cleared", 32'(fetch_err), 32'd0);

        // wrap at top of address space, then reset mid-fetch
        run_instr(32'h1000_F3FE, 1'b0, 2'b10, 1'b1);
        chk("to_top", pc, 32'hFFFF_FFFC);
        run_instr(32'h0, 1'b0, 2'b00, 1'b0);
        chk("wrap_zero", pc, 32'h0);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; rst = 1;
        tick();
        rst = 0; imem_ack = 0;
        chk("rst_fetch_instr", instr, 32'h0);
        chk("rst_fetch_pc", pc, RPC);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 9) < 3);
            imem_ack = ($urandom_range(0, 9) < 7);
            imem_rdata = $urandom;
            randomize_ctrl();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
